// File: rtl/simon_playback_reader.sv
`default_nettype none
// ============================================================================
// Module   : simon_playback_reader
// Function : Replays stored Simon patterns from the pattern RAM onto the LEDs
//            with a fixed lit time and a fixed blank gap between patterns.
// Revision : 1.0 - initial release
// ============================================================================
module simon_playback_reader #(
    parameter int ADDR_W      = 5,
    parameter int HOLD_CYCLES = 25000000,
    parameter int GAP_CYCLES  = 12500000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   count,
    input  logic              abort,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [3:0]        rd_data,
    output logic [3:0]        leds,
    output logic              busy,
    output logic              done
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int T_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [TW-1:0]   HOLD_LOAD = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0]   GAP_LOAD  = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [TW-1:0]   T_ONE     = TW'(1);
    localparam logic [ADDR_W:0] DEPTH_W   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] IDX_ONE   = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_SHOW  = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t          r_state;
    logic [ADDR_W:0] r_idx;
    logic [ADDR_W:0] r_n;
    logic [TW-1:0]   r_timer;

    logic [ADDR_W:0] w_n_clamp;
    logic [ADDR_W:0] w_idx_next;
    logic            w_last;

    assign w_n_clamp  = (count > DEPTH_W) ? DEPTH_W : count;
    assign w_idx_next = r_idx + IDX_ONE;
    assign w_last     = (r_idx == (r_n - IDX_ONE));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_n     <= '0;
            r_timer <= '0;
            leds    <= '0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            rd_en <= 1'b0;
            done  <= 1'b0;
            if (abort) begin
                r_state <= S_IDLE;
                leds    <= '0;
                busy    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_n   <= w_n_clamp;
                            r_idx <= '0;
                            busy  <= 1'b1;
                            if (w_n_clamp == '0) begin
                                r_state <= S_DONE;
                                done    <= 1'b1;
                            end else begin
                                r_state <= S_FETCH;
                                rd_en   <= 1'b1;
                                rd_addr <= '0;
                            end
                        end
                    end
                    S_FETCH: r_state <= S_WAIT;
                    S_WAIT: begin
                        // rd_data is only trusted here; any other cycle may carry junk.
                        leds    <= rd_data;
                        r_timer <= HOLD_LOAD;
                        r_state <= S_SHOW;
                    end
                    S_SHOW: begin
                        if (r_timer == '0) begin
                            leds <= '0;
                            if (GAP_CYCLES > 0) begin
                                r_timer <= GAP_LOAD;
                                r_state <= S_GAP;
                            end else if (w_last) begin
                                r_state <= S_DONE;
                                done    <= 1'b1;
                            end else begin
                                r_idx   <= w_idx_next;
                                rd_en   <= 1'b1;
                                rd_addr <= w_idx_next[ADDR_W-1:0];
                                r_state <= S_FETCH;
                            end
                        end else begin
                            r_timer <= r_timer - T_ONE;
                        end
                    end
                    S_GAP: begin
                        if (r_timer == '0) begin
                            if (w_last) begin
                                r_state <= S_DONE;
                                done    <= 1'b1;
                            end else begin
                                r_idx   <= w_idx_next;
                                rd_en   <= 1'b1;
                                rd_addr <= w_idx_next[ADDR_W-1:0];
                                r_state <= S_FETCH;
                            end
                        end else begin
                            r_timer <= r_timer - T_ONE;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        leds    <= '0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_simon_playback_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_simon_playback_reader
// Function : Self-checking bench; expected LED/RAM/handshake timelines are
//            built from the playback timing rules and compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_simon_playback_reader;

    localparam int ADDR_W = 3;
    localparam int HOLD   = 4;
    localparam int GAP    = 2;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   count;
    logic              abort;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [3:0]        rd_data;
    logic [3:0]        leds;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    simon_playback_reader #(
        .ADDR_W      (ADDR_W),
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .count   (count),
        .abort   (abort),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .leds    (leds),
        .busy    (busy),
        .done    (done)
    );

    // Pattern RAM: 1-cycle synchronous read, junk on the bus whenever no read was issued.
    logic [3:0] mem [DEPTH];
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
        else       rd_data <= 4'($urandom);
    end

    typedef struct packed {
        logic       en;
        logic [2:0] addr;
        logic [3:0] led;
        logic       bsy;
        logic       dn;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
    endtask

    function automatic exp_t mk(input logic en, input int addr, input int led,
                                input logic bsy, input logic dn);
        exp_t e;
        e.en   = en;
        e.addr = 3'(addr);
        e.led  = 4'(led);
        e.bsy  = bsy;
        e.dn   = dn;
        return e;
    endfunction

    // Expected cycle-by-cycle timeline, starting with the cycle after the start edge.
    task automatic build(input int cnt);
        int n;
        n = (cnt > DEPTH) ? DEPTH : cnt;
        q.delete();
        for (int i = 0; i < n; i++) begin
            q.push_back(mk(1'b1, i, 0, 1'b1, 1'b0));
            q.push_back(mk(1'b0, 0, 0, 1'b1, 1'b0));
            for (int h = 0; h < HOLD; h++) q.push_back(mk(1'b0, 0, int'(mem[i]), 1'b1, 1'b0));
            for (int g = 0; g < GAP; g++)  q.push_back(mk(1'b0, 0, 0, 1'b1, 1'b0));
        end
        q.push_back(mk(1'b0, 0, 0, 1'b1, 1'b1));
    endtask

    task automatic compare(input exp_t e, input string ph);
        check_val({ph, ".rd_en"}, int'(rd_en), int'(e.en));
        if (e.en) check_val({ph, ".rd_addr"}, int'(rd_addr), int'(e.addr));
        check_val({ph, ".leds"}, int'(leds), int'(e.led));
        check_val({ph, ".busy"}, int'(busy), int'(e.bsy));
        check_val({ph, ".done"}, int'(done), int'(e.dn));
    endtask

    // Called at a negedge with the DUT idle; abort_at/restart_at index the timeline
    // (-1 = none, -2 = abort on the final gap cycle).
    task automatic run(input string ph, input int cnt, input int abort_at_in, input int restart_at);
        int  abort_at;
        bit  aborted;
        abort_at = abort_at_in;
        aborted  = 1'b0;
        build(cnt);
        if (abort_at == -2) abort_at = q.size() - 2;
        start = 1'b1;
        count = (ADDR_W + 1)'(cnt);
        @(negedge clk);
        start = 1'b0;
        count = (ADDR_W + 1)'($urandom_range(0, 15));
        for (int j = 0; j < q.size(); j++) begin
            compare(q[j], ph);
            if (j == restart_at) begin
                start = 1'b1;
                count = 1;
            end
            abort = (j == abort_at);
            @(negedge clk);
            start = 1'b0;
            if (abort) begin
                abort   = 1'b0;
                aborted = 1'b1;
                break;
            end
        end
        compare(mk(1'b0, 0, 0, 1'b0, 1'b0), {ph, aborted ? ".after_abort" : ".after_done"});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        count = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 4'(1 << (i % 4));
        @(negedge clk);
        @(negedge clk);
        compare(mk(1'b0, 0, 0, 1'b0, 1'b0), "reset");
        check_val("reset.rd_addr", int'(rd_addr), 0);
        rst = 1'b1;
        @(negedge clk);

        run("basic3", 3, -1, -1);
        run("count0", 0, -1, -1);
        for (int i = 0; i < DEPTH; i++) mem[i] = 4'($urandom_range(1, 15));
        run("clamp12", 12, -1, -1);
        run("abort_show2", 4, 11, -1);
        run("replay", 2, -1, -1);
        run("restart_ignored", 3, -1, 5);
        run("abort_last_gap", 2, -2, -1);

        // start with abort in IDLE: abort wins.
        start = 1'b1;
        abort = 1'b1;
        count = 4'd3;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        compare(mk(1'b0, 0, 0, 1'b0, 1'b0), "start_abort");
        @(negedge clk);
        compare(mk(1'b0, 0, 0, 1'b0, 1'b0), "start_abort2");

        for (int r = 0; r < 20; r++) begin
            int cnt, ab, rs;
            for (int i = 0; i < DEPTH; i++) mem[i] = 4'($urandom_range(0, 15));
            cnt = $urandom_range(0, 15);
            build(cnt);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, q.size() - 1) : -1;
            rs = ($urandom_range(0, 3) == 0) ? $urandom_range(0, q.size() - 1) : -1;
            run("random", cnt, ab, rs);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Asynchronous reset in the middle of SHOW.
        for (int i = 0; i < DEPTH; i++) mem[i] = 4'($urandom_range(1, 15));
        build(5);
        start = 1'b1;
        count = 4'd5;
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < 4; j++) begin
            compare(q[j], "pre_reset");
            @(negedge clk);
        end
        #2 rst = 1'b0;
        #1;
        compare(mk(1'b0, 0, 0, 1'b0, 1'b0), "async_reset");
        @(negedge clk);
        compare(mk(1'b0, 0, 0, 1'b0, 1'b0), "in_reset");
        rst = 1'b1;
        @(negedge clk);
        compare(mk(1'b0, 0, 0, 1'b0, 1'b0), "post_reset");
        run("post_reset_run", 2, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
